// File: rtl/neuron_mac_ctrl.sv
// neuron_mac_ctrl: sequences one neuron evaluation (bias + dot product, then activation) over a valid/ready stream.
// Define NEURON_RELU_EN for a ReLU activation; otherwise the activation is linear with unit derivative.
module neuron_mac_ctrl #(
    parameter int DW    = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [DW-1:0]    bias,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    a_data,
    input  logic [DW-1:0]    b_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    y,
    output logic             d,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, ACT, DONE} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    acc_q, acc_d, y_q, y_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic             d_q, d_d;
    logic [DW-1:0]    prod, act_y;
    logic             act_d;

    // Truncated two's-complement product: low DW bits are sign-agnostic.
    assign prod = a_data * b_data;

`ifdef NEURON_RELU_EN
    assign act_y = acc_q[DW-1] ? '0 : acc_q;
    assign act_d = !acc_q[DW-1] && (acc_q != '0);
`else
    assign act_y = acc_q;
    assign act_d = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        y_d     = y_q;
        d_d     = d_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    acc_d   = bias;
                    state_d = (len != '0) ? ACCUM : ACT;
                end
                ACCUM: if (in_valid) begin
                    acc_d   = acc_q + prod;
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_q == len_q - LEN_W'(1)) ? ACT : ACCUM;
                end
                ACT: begin
                    y_d     = act_y;
                    d_d     = act_d;
                    state_d = DONE;
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            y_q     <= '0;
            d_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            y_q     <= y_d;
            d_q     <= d_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;
    assign d         = d_q;
endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// tb_neuron_mac_ctrl: table-driven vectors with a result scoreboard, plus abort/reset sequences.
module tb_neuron_mac_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [31:0] bias = '0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_data = '0;
    logic [31:0] b_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y;
    logic        d;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [32:0] sb[$];

    neuron_mac_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .d(d), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    typedef struct packed {
        logic [31:0]      bias;
        logic [7:0]       len;
        logic [0:3][31:0] a;
        logic [0:3][31:0] b;
        logic [31:0]      ylin;
        logic [31:0]      yrelu;
        logic             drelu;
        logic             gaps;
        logic [7:0]       stall;
    } vec_t;

    vec_t v[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [32:0] expect_of(input int i);
`ifdef NEURON_RELU_EN
        return {v[i].yrelu, v[i].drelu};
`else
        return {v[i].ylin, 1'b1};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int i);
        int cyc, k;
        logic took, saw_ready;
        logic [32:0] held, exp;
        sb.push_back(expect_of(i));
        start = 1'b1; len = v[i].len; bias = v[i].bias;
        tick();
        start = 1'b0;
        cyc = 1; k = 0; saw_ready = 1'b0;
        while (!out_valid && cyc < 300) begin
            saw_ready |= in_ready;
            if (in_ready && k < int'(v[i].len)) begin
                a_data = v[i].a[k]; b_data = v[i].b[k];
                in_valid = v[i].gaps ? cyc[0] : 1'b1;
            end else in_valid = 1'b0;
            took = in_valid && in_ready;
            tick();
            if (took) k++;
            cyc++;
        end
        in_valid = 1'b0;
        check($sformatf("v%0d out_valid_seen", i), 32'(out_valid), 32'd1);
        check($sformatf("v%0d beats", i), k, 32'(v[i].len));
        if (!v[i].gaps) check($sformatf("v%0d latency", i), cyc, 32'(v[i].len) + 2);
        if (v[i].len == 0) check($sformatf("v%0d no_in_ready", i), 32'(saw_ready), 32'd0);
        held = {y, d};
        for (int s = 0; s < int'(v[i].stall); s++) begin
            start = s[0] ? 1'b0 : 1'b1;
            tick();
            check($sformatf("v%0d stall_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d stall_y", i), y, held[32:1]);
            check($sformatf("v%0d stall_d", i), 32'(d), 32'(held[0]));
        end
        start = 1'b0;
        out_ready = 1'b1;
        exp = sb.pop_front();
        check($sformatf("v%0d y", i), y, exp[32:1]);
        check($sformatf("v%0d d", i), 32'(d), 32'(exp[0]));
        tick();
        out_ready = 1'b0;
        check($sformatf("v%0d idle_after", i), {30'd0, busy, out_valid}, 32'd0);
    endtask

    task automatic feed(input int n, input logic [31:0] av, input logic [31:0] bv);
        for (int j = 0; j < n; j++) begin
            a_data = av; b_data = bv; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] last_y;
        v[0] = '{bias: 32'd5, len: 8'd3, a: '{32'd1, 32'd2, 32'd3, 32'd0}, b: '{32'd4, -32'sd5, 32'd6, 32'd0},
                 ylin: 32'd17, yrelu: 32'd17, drelu: 1'b1, gaps: 1'b0, stall: 8'd0};
        v[1] = '{bias: 32'd0, len: 8'd1, a: '{32'd2, 32'd0, 32'd0, 32'd0}, b: '{-32'sd3, 32'd0, 32'd0, 32'd0},
                 ylin: 32'hFFFFFFFA, yrelu: 32'd0, drelu: 1'b0, gaps: 1'b0, stall: 8'd0};
        v[2] = '{bias: 32'd1, len: 8'd1, a: '{32'h7FFFFFFF, 32'd0, 32'd0, 32'd0}, b: '{32'd1, 32'd0, 32'd0, 32'd0},
                 ylin: 32'h80000000, yrelu: 32'd0, drelu: 1'b0, gaps: 1'b0, stall: 8'd0};
        v[3] = '{bias: -32'sd7, len: 8'd0, a: '0, b: '0,
                 ylin: 32'hFFFFFFF9, yrelu: 32'd0, drelu: 1'b0, gaps: 1'b0, stall: 8'd0};
        v[4] = '{bias: 32'd9, len: 8'd0, a: '0, b: '0,
                 ylin: 32'd9, yrelu: 32'd9, drelu: 1'b1, gaps: 1'b0, stall: 8'd0};
        v[5] = '{bias: 32'd100, len: 8'd4, a: '{32'd3, -32'sd2, 32'd7, 32'd10}, b: '{32'd5, 32'd8, -32'sd1, 32'd2},
                 ylin: 32'd112, yrelu: 32'd112, drelu: 1'b1, gaps: 1'b1, stall: 8'd5};
        v[6] = '{bias: -32'sd1000, len: 8'd2, a: '{-32'sd3, 32'd4, 32'd0, 32'd0}, b: '{-32'sd4, -32'sd5, 32'd0, 32'd0},
                 ylin: 32'hFFFFFC10, yrelu: 32'd0, drelu: 1'b0, gaps: 1'b0, stall: 8'd0};
        v[7] = '{bias: 32'd3, len: 8'd1, a: '{32'd2, 32'd0, 32'd0, 32'd0}, b: '{32'd2, 32'd0, 32'd0, 32'd0},
                 ylin: 32'd7, yrelu: 32'd7, drelu: 1'b1, gaps: 1'b0, stall: 8'd0};

        #3;
        check("reset outputs", {28'd0, in_ready, out_valid, busy, d}, 32'd0);
        check("reset y", y, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run(i);
        last_y = expect_of(6) >> 1;

        // Abort after two of four beats; the beat in the clear cycle must not matter.
        start = 1'b1; len = 8'd4; bias = 32'd50;
        tick();
        start = 1'b0;
        feed(2, 32'd10, 32'd10);
        clear = 1'b1; in_valid = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clear busy", {30'd0, busy, in_ready}, 32'd0);
        check("clear out_valid", 32'(out_valid), 32'd0);
        check("clear keeps y", y, last_y);
        tick();
        check("clear stays idle", 32'(busy), 32'd0);
        run(7);

        // clear beats start in the same IDLE cycle.
        start = 1'b1; clear = 1'b1; len = 8'd1; bias = 32'd1;
        tick();
        start = 1'b0; clear = 1'b0;
        check("clear+start idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of accumulation.
        start = 1'b1; len = 8'd3; bias = 32'd20;
        tick();
        start = 1'b0;
        feed(1, 32'd4, 32'd4);
        check("mid accum busy", {30'd0, busy, in_ready}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("async rst flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
        check("async rst y", y, 32'd0);
        check("async rst d", 32'(d), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run(0);
        run(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/neuron_mac_ctrl.md
# neuron_mac_ctrl

Sequencing controller for one neuron evaluation in the DNN training datapath. The block time-shares a single `multiplier` / `adder` pair over a streamed operand vector, then applies `relu` once per neuron. It accepts a start command with vector length and bias, consumes `len` operand pairs over a valid/ready stream, and presents the activation and its derivative on a valid/ready output port. Upstream layer control sits in front of it; weight-update logic consumes `y` and `d`.

## Interface
- `DW`, 32: datapath width; fixed to match `multiplier` / `adder` / `relu`.
- `LEN_W`, 8: width of the vector-length field; max vector length is 2^LEN_W−1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs; latched on accepted start.
- `bias`  in  DW  signed initial accumulator value; latched on accepted start.
- `clear`  in  1  synchronous abort; returns to IDLE from any state.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller can accept an operand pair.
- `a_data`, `b_data`  in  DW each  signed operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `y`  out  DW  signed activation.
- `d`  out  1  activation derivative.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ACCUM, ACT, DONE.
- IDLE: `start` = 1 latches `len` into the length register, clears the beat counter, and loads `bias` into the accumulator. It then goes to ACCUM if `len` ≠ 0, otherwise to ACT.
- ACCUM: `in_ready` = 1. Each beat with `in_valid && in_ready` does acc ← adder(acc, multiplier(a_data, b_data)) and increments the counter. The beat where counter = len−1 moves to ACT.
- ACT: one cycle. Registers `relu(acc)` into `y` and `d`, then moves to DONE.
- DONE: `out_valid` = 1 with `y` and `d` held stable. `out_ready` = 1 returns to IDLE.
- Arithmetic: products and sums are truncated two's complement, mod 2^32, with no saturation. Overflow wraps and propagates into `relu`.
- `start` outside IDLE is ignored (no queueing).
- `clear` has priority over every transition, including a handshake in the same cycle. It forces IDLE, drops `out_valid` and `in_ready`, and leaves `y` / `d` unchanged. A beat presented in the `clear` cycle is not consumed.
- `clear` and `start` in the same IDLE cycle: `clear` wins, and `start` is dropped.
- Asynchronous reset mid-operation: immediate IDLE, and all outputs go to reset values. A partial accumulation is discarded.

## Timing
- Reset values: `in_ready` = 0, `out_valid` = 0, `busy` = 0, `y` = 0, `d` = 0. Accumulator, counter and length register = 0.
- `start` accepted at edge 0. `in_ready` is high from cycle 1.
- With `in_valid` held high, beats occur in cycles 1..len, ACT in cycle len+1, and `out_valid` rises in cycle len+2. Minimum start-to-result latency is len+2 cycles.
- `len` = 0: ACT in cycle 1, `out_valid` in cycle 2, and the result is `relu(bias)`.
- `in_valid` gaps stall the counter without limit, and the accumulator holds.
- `out_valid` stays high until the cycle `out_ready` = 1. The next `start` is accepted at the earliest in the cycle after that handshake, giving back-to-back neurons with one IDLE cycle between them.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- `NEURON_RELU_EN` defined: ACT registers `y` = `relu(acc).y` and `d` = `relu(acc).d`.
- `NEURON_RELU_EN` undefined: `relu` is not instantiated. ACT registers `y` = acc and `d` = 1 (linear activation, unit derivative). Timing is unchanged.

## Test plan
- Basic dot product: bias = 5, len = 3, a = {1, 2, 3}, b = {4, −5, 6}, continuous valid. Requires `y` = 17, `d` = 1, with `out_valid` at cycle 5 after start.
- Negative result: bias = 0, len = 1, a = 2, b = −3. With the macro, `y` = 0 and `d` = 0. Without it, `y` = 0xFFFFFFFA and `d` = 1.
- Overflow wrap: bias = 1, len = 1, a = 0x7FFFFFFF, b = 1. Accumulator is 0x80000000, so `y` = 0, `d` = 0 (macro on).
- Zero length: len = 0, bias = −7. No `in_ready` pulse. `out_valid` at cycle 2 with `y` = 0, `d` = 0. Repeat with bias = 9 and expect `y` = 9, `d` = 1.
- Stalls and backpressure: len = 4 with `in_valid` toggling, then `out_ready` low for 5 cycles while `start` pulses. Requires the correct sum, `y` / `d` stable across the stall, and `start` ignored.
- Abort and reset: assert `clear` after 2 of 4 beats. Requires IDLE next cycle, `busy` = 0, and a new start computing from the new bias. Then deassert `rst_n` mid-ACCUM: all outputs go to 0 immediately.
